mem_port_arbiter: RTL and testbench

//  Shares one memory port between NUM_REQ requesters (e.g. fetch, LSU) with round-robin arbitration.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_rr_arbiter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and the round-robin pick function for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {IDLE, RD_WAIT} arb_state_t;

  localparam int unsigned MAX_REQ = 32;

  // Scans from ptr+n-1 down to ptr so the nearest valid index to ptr is taken last.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    rr_pick = ptr;
    for (int unsigned i = n; i > 0; i--) begin
      idx = ptr + i - 1;
      if (idx >= n) idx = idx - n;
      if (valid[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant starting the search at ptr.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any,
  output logic [PW-1:0] idx
);

  logic [MAX_REQ-1:0] w_req_ext;
  int unsigned        w_pick;

  always_comb begin
    w_req_ext        = '0;
    w_req_ext[N-1:0] = req;
    w_pick           = rr_pick(w_req_ext, 32'(ptr), N);
    idx              = PW'(w_pick);
    any              = |req;
    gnt              = '0;
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one memory port among NUM_REQ requesters; one read outstanding, posted writes.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      mem_ren,
  output logic [ADDR_W-1:0]         mem_raddr,
  input  logic                      mem_rvalid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      mem_wen,
  output logic [ADDR_W-1:0]         mem_waddr,
  output logic [DATA_W-1:0]         mem_wdata
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          r_state, w_state_nxt;
  logic [PW-1:0]       r_rr_ptr, r_owner, w_idx, w_ptr_nxt;
  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_any, w_accept, w_rd_done;

  logic                r_mem_ren, r_mem_wen;
  logic [ADDR_W-1:0]   r_mem_raddr, r_mem_waddr;
  logic [DATA_W-1:0]   r_mem_wdata, r_rsp_data;
  logic [NUM_REQ-1:0]  r_rsp_valid;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .gnt (w_gnt),
    .any (w_any),
    .idx (w_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rd_done   = 1'b0;
    w_ptr_nxt   = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    case (r_state)
      IDLE: begin
        w_accept = w_any;
        if (w_any && !req_we[w_idx]) w_state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        w_rd_done = mem_rvalid;
        if (mem_rvalid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_mem_ren   <= 1'b0;
      r_mem_raddr <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_mem_wen   <= 1'b0;
      r_rsp_valid <= '0;
      if (w_accept) begin
        r_rr_ptr <= w_ptr_nxt;
        if (req_we[w_idx]) begin
          r_mem_wen   <= 1'b1;
          r_mem_waddr <= req_addr[w_idx*ADDR_W +: ADDR_W];
          r_mem_wdata <= req_wdata[w_idx*DATA_W +: DATA_W];
        end else begin
          r_mem_ren   <= 1'b1;
          r_mem_raddr <= req_addr[w_idx*ADDR_W +: ADDR_W];
          r_owner     <= w_idx;
        end
      end
      if (w_rd_done) begin
        r_mem_ren            <= 1'b0;
        r_rsp_valid[r_owner] <= 1'b1;
        r_rsp_data           <= mem_rdata;
      end
    end
  end

  // Grant is masked during reset so every output reads 0 while rst_n is low.
  assign req_ready = (rst_n && r_state == IDLE) ? w_gnt : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign mem_ren   = r_mem_ren;
  assign mem_raddr = r_mem_raddr;
  assign mem_wen   = r_mem_wen;
  assign mem_waddr = r_mem_waddr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with two requesters.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid, req_we, req_ready, rsp_valid;
  logic [127:0] req_addr, req_wdata;
  logic [63:0]  rsp_data, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic         mem_ren, mem_rvalid, mem_wen;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [63:0] a, input logic [63:0] d);
    req_valid[i]          = v;
    req_we[i]             = we;
    req_addr[i*64 +: 64]  = a;
    req_wdata[i*64 +: 64] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    req_we = 2'b00; req_addr = '0; req_wdata = '0;
    req_valid = 2'b11;
    #2;
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    total++;
    if ({mem_ren, mem_wen, rsp_valid} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_ren, mem_wen, rsp_valid});
    end
    total++;
    if ({mem_raddr, mem_waddr, mem_wdata, rsp_data} !== 256'b0) begin
      bad++; $display("FAIL reset_data: got raddr=%h waddr=%h wdata=%h rsp=%h expected all 0",
                      mem_raddr, mem_waddr, mem_wdata, rsp_data);
    end
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    int ren_cycles = 0;
    set_req(0, 1'b1, 1'b0, 64'h100, 64'h0);
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL rd_grant: got %b expected 01", req_ready); end
    tick();
    set_req(0, 1'b0, 1'b0, 64'h0, 64'h0);
    #1;
    total++;
    if (mem_raddr !== 64'h100) begin bad++; $display("FAIL rd_raddr: got %h expected 100", mem_raddr); end
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL rd_wait_ready: got %b expected 00", req_ready); end
    for (int c = 0; c < 3; c++) begin
      if (mem_ren === 1'b1) ren_cycles++;
      if (c == 2) begin mem_rvalid = 1'b1; mem_rdata = 64'hDEAD; end
      tick();
    end
    mem_rvalid = 1'b0;
    total++;
    if (ren_cycles !== 3) begin bad++; $display("FAIL rd_ren_len: got %0d expected 3", ren_cycles); end
    total++;
    if ({mem_ren, rsp_valid} !== 3'b001) begin
      bad++; $display("FAIL rd_rsp: got ren=%b rsp_valid=%b expected ren=0 rsp_valid=01", mem_ren, rsp_valid);
    end
    total++;
    if (rsp_data !== 64'hDEAD) begin bad++; $display("FAIL rd_rsp_data: got %h expected dead", rsp_data); end
    tick();
    total++;
    if (rsp_valid !== 2'b00 || rsp_data !== 64'hDEAD) begin
      bad++; $display("FAIL rd_rsp_pulse: got rsp_valid=%b data=%h expected 00 dead", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g;
    logic [63:0] exp_a, exp_d;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    set_req(0, 1'b1, 1'b1, 64'h10, 64'hA0A0);
    set_req(1, 1'b1, 1'b1, 64'h20, 64'hB1B1);
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      exp_a = (k % 2 == 1) ? 64'h20 : 64'h10;
      exp_d = (k % 2 == 1) ? 64'hB1B1 : 64'hA0A0;
      total++;
      if (req_ready !== exp_g) begin bad++; $display("FAIL wr_grant[%0d]: got %b expected %b", k, req_ready, exp_g); end
      tick();
      total++;
      if (mem_wen !== 1'b1 || mem_waddr !== exp_a || mem_wdata !== exp_d) begin
        bad++; $display("FAIL wr_beat[%0d]: got wen=%b addr=%h data=%h expected 1 %h %h",
                        k, mem_wen, mem_waddr, mem_wdata, exp_a, exp_d);
      end
    end
    req_valid = 2'b00;
    tick();
    total++;
    if (mem_wen !== 1'b0 || mem_waddr !== 64'h20 || mem_wdata !== 64'hB1B1) begin
      bad++; $display("FAIL wr_idle_hold: got wen=%b addr=%h data=%h expected 0 20 b1b1", mem_wen, mem_waddr, mem_wdata);
    end
  endtask

  task automatic test_read_blocks();
    set_req(1, 1'b1, 1'b0, 64'h180, 64'h0);
    #1;
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL blk_grant1: got %b expected 10", req_ready); end
    tick();
    set_req(1, 1'b0, 1'b0, 64'h0, 64'h0);
    set_req(0, 1'b1, 1'b1, 64'h10, 64'h1111);
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (req_ready !== 2'b00 || mem_raddr !== 64'h180) begin
        bad++; $display("FAIL blk_wait[%0d]: got ready=%b raddr=%h expected 00 180", c, req_ready, mem_raddr);
      end
      if (c == 1) begin mem_rvalid = 1'b1; mem_rdata = 64'hBEEF; end
      tick();
    end
    mem_rvalid = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 2'b10 || rsp_data !== 64'hBEEF || req_ready !== 2'b01) begin
      bad++; $display("FAIL blk_rsp_grant: got rsp=%b data=%h ready=%b expected 10 beef 01", rsp_valid, rsp_data, req_ready);
    end
    tick();
    req_valid = 2'b00;
    total++;
    if (mem_wen !== 1'b1 || mem_waddr !== 64'h10 || mem_wdata !== 64'h1111 || rsp_valid !== 2'b00) begin
      bad++; $display("FAIL blk_wr: got wen=%b addr=%h data=%h rsp=%b expected 1 10 1111 00",
                      mem_wen, mem_waddr, mem_wdata, rsp_valid);
    end
  endtask

  task automatic test_spurious_abort();
    mem_rvalid = 1'b1; mem_rdata = 64'h55;
    tick();
    mem_rvalid = 1'b0;
    total++;
    if (rsp_valid !== 2'b00 || rsp_data !== 64'hBEEF || mem_ren !== 1'b0) begin
      bad++; $display("FAIL spurious: got rsp=%b data=%h ren=%b expected 00 beef 0", rsp_valid, rsp_data, mem_ren);
    end
    set_req(0, 1'b1, 1'b0, 64'h200, 64'h0);
    tick();
    set_req(0, 1'b0, 1'b0, 64'h0, 64'h0);
    total++;
    if (mem_ren !== 1'b1 || mem_raddr !== 64'h200) begin
      bad++; $display("FAIL abort_issue: got ren=%b raddr=%h expected 1 200", mem_ren, mem_raddr);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_ren, mem_wen, rsp_valid, req_ready} !== 6'b0 || {mem_raddr, mem_waddr, mem_wdata, rsp_data} !== 256'b0) begin
      bad++; $display("FAIL abort_reset: got ren=%b wen=%b rsp=%b ready=%b raddr=%h rsp_data=%h expected all 0",
                      mem_ren, mem_wen, rsp_valid, req_ready, mem_raddr, rsp_data);
    end
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h77;
    tick();
    mem_rvalid = 1'b0;
    total++;
    if (rsp_valid !== 2'b00 || rsp_data !== 64'h0 || mem_ren !== 1'b0) begin
      bad++; $display("FAIL abort_late_rvalid: got rsp=%b data=%h ren=%b expected 00 0 0", rsp_valid, rsp_data, mem_ren);
    end
    req_valid = 2'b11; req_we = 2'b00;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL abort_idle_ptr: got %b expected 01", req_ready); end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_withdraw();
    set_req(0, 1'b1, 1'b0, 64'h300, 64'h0);
    tick();
    set_req(0, 1'b0, 1'b0, 64'h0, 64'h0);
    set_req(1, 1'b1, 1'b1, 64'h20, 64'h2222);
    #1;
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL wd_ready: got %b expected 00", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'h99;
    tick();
    mem_rvalid = 1'b0;
    total++;
    if (rsp_valid !== 2'b01 || rsp_data !== 64'h99 || mem_wen !== 1'b0) begin
      bad++; $display("FAIL wd_rsp: got rsp=%b data=%h wen=%b expected 01 99 0", rsp_valid, rsp_data, mem_wen);
    end
    set_req(0, 1'b1, 1'b1, 64'h10, 64'h1111);
    set_req(1, 1'b1, 1'b1, 64'h20, 64'h2222);
    #1;
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL wd_ptr: got %b expected 10", req_ready); end
    tick();
    total++;
    if (mem_wen !== 1'b1 || mem_waddr !== 64'h20 || req_ready !== 2'b01) begin
      bad++; $display("FAIL wd_wrap: got wen=%b addr=%h ready=%b expected 1 20 01", mem_wen, mem_waddr, req_ready);
    end
    tick();
    req_valid = 2'b00;
    total++;
    if (mem_wen !== 1'b1 || mem_waddr !== 64'h10 || mem_wdata !== 64'h1111) begin
      bad++; $display("FAIL wd_after_wrap: got wen=%b addr=%h data=%h expected 1 10 1111", mem_wen, mem_waddr, mem_wdata);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_read_blocks();
    test_spurious_abort();
    test_withdraw();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
